// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the simple-dual-port FIFO controller.
package fifo_pkg;

    // Kind of pointer movement accepted in one cycle, {push_acc, pop_acc}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Number of words held by a RAM with the given address width.
    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage : fifo_pkg

// File: rtl/simple_dual_port_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port
// (read latency 1). Read-during-write to the same address returns old data.
module simple_dual_port_ram
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr_w,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] addr_r,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] dout_d;
    logic [DATA_WIDTH-1:0] dout_q;

    // Write port: store the word when enabled.
    // NOTE: the storage array has no reset; clearing it would need a
    // per-word reset network and prevent mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr_w] <= din;
        end
    end

    // Read port address decode.
    always_comb begin
        dout_d = mem[addr_r];
    end

    // Read data register: one cycle of latency.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        dout_q <= dout_d;
    end

    assign dout = dout_q;

endmodule : simple_dual_port_ram

// File: rtl/sdp_fifo_ctrl.sv
// Synchronous FIFO controller sequencing one simple_dual_port_ram.
// Tracks pointers and occupancy, produces status and sticky error flags.
module sdp_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int AF_THRESH  = 2**ADDR_WIDTH - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] COUNT_MAX = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AF_LVL    = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_LVL    = PTR_W'(AE_THRESH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count_q,  count_d;
    logic             pop_valid_q, pop_valid_d;
    logic             overflow_q,  overflow_d;
    logic             underflow_q, underflow_d;

    logic             push_acc;
    logic             pop_acc;
    logic             ram_we;
    fifo_op_e         op;

    // Status flags, all derived from registered state only.
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                          (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);

    // A request is accepted only if the registered state allows it.
    assign push_acc = push && !full;
    assign pop_acc  = pop && !empty;
    assign op       = fifo_op_e'({push_acc, pop_acc});

    // A push in a flush cycle is dropped, so it must not reach the RAM.
    assign ram_we   = push_acc && !flush;

    // Next-state computation for pointers, occupancy and flags.
    // NOTE: every signal gets a default first, so no path leaves a value
    // unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pop_valid_d = pop_acc;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            // Flush wins over push and pop; sticky flags survive it.
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            pop_valid_d = 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end

            unique case (op)
                OP_PUSH: count_d = count_q + PTR_ONE;
                OP_POP:  count_d = count_q - PTR_ONE;
                OP_BOTH: count_d = count_q;
                OP_IDLE: count_d = count_q;
                default: count_d = count_q;
            endcase

            if (push && full) begin
                overflow_d = 1'b1;
            end
            if (pop && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign pop_valid = pop_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Storage; read address always tracks the head so the word is ready
    // one cycle after the pop that consumes it.
    simple_dual_port_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .addr_w (wr_ptr_q[ADDR_WIDTH-1:0]),
        .din    (push_data),
        .addr_r (rd_ptr_q[ADDR_WIDTH-1:0]),
        .dout   (pop_data)
    );

    // Occupancy stays in range and always matches the pointer distance.
    a_count_range : assert property (@(posedge clk) disable iff (reset)
        count_q <= COUNT_MAX);
    a_count_ptrs : assert property (@(posedge clk) disable iff (reset)
        count_q == PTR_W'(wr_ptr_q - rd_ptr_q));

endmodule : sdp_fifo_ctrl

// File: tb/tb_sdp_fifo_ctrl.sv
// Self-checking bench for sdp_fifo_ctrl (depth 4). A behavioural queue model
// predicts pop data; predicted words wait in a scoreboard until the DUT
// presents pop_valid.
module tb_sdp_fifo_ctrl;

    localparam int AW    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] sb_q[$];
    bit            m_ovf;
    bit            m_unf;

    sdp_fifo_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .push         (push),
        .push_data    (push_data),
        .pop          (pop),
        .pop_data     (pop_data),
        .pop_valid    (pop_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model, then compare after the edge.
    task automatic step(input logic r, input logic f, input logic p,
                        input logic [DW-1:0] d, input logic q);
        bit            m_full;
        bit            m_empty;
        bit            exp_v;
        int            sz;
        logic [DW-1:0] w;

        reset     = r;
        flush     = f;
        push      = p;
        push_data = d;
        pop       = q;

        m_full  = (model_q.size() == DEPTH);
        m_empty = (model_q.size() == 0);
        exp_v   = 1'b0;

        if (r) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (f) begin
            model_q.delete();
        end else begin
            if (p && m_full)  m_ovf = 1'b1;
            if (q && m_empty) m_unf = 1'b1;
            if (q && !m_empty) begin
                exp_v = 1'b1;
                sb_q.push_back(model_q.pop_front());
            end
            if (p && !m_full) model_q.push_back(d);
        end

        @(posedge clk);
        #1;

        check("pop_valid", 32'(pop_valid), 32'(exp_v));
        if (sb_q.size() != 0) begin
            w = sb_q.pop_front();
            check("pop_data", 32'(pop_data), 32'(w));
        end

        sz = model_q.size();
        check("count",        32'(count),        32'(sz));
        check("full",         32'(full),         32'(sz == DEPTH));
        check("empty",        32'(empty),        32'(sz == 0));
        check("almost_full",  32'(almost_full),  32'(sz >= AF));
        check("almost_empty", 32'(almost_empty), 32'(sz <= AE));
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("underflow",    32'(underflow),    32'(m_unf));
    endtask

    initial begin
        logic [DW-1:0] t1_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

        reset = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
        m_ovf = 1'b0; m_unf = 1'b0;

        // Reset state.
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // 1: fill to full, drain in order.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, t1_data[i], 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // 2: overflow on push while full, sticky through the drain.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h01 + i), 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // 3: underflow on pop while empty, then push+pop while empty.
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h66, 1'b1);

        // 4: steady push+pop at count 2 across the pointer wrap.
        step(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h80 + i), 1'b1);

        // 5: flush with a concurrent push at count 3; flags survive.
        step(1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // 6: reset with a pop in flight at count 2.
        step(1'b0, 1'b0, 1'b1, 8'hC1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hC2, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hC3, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sdp_fifo_ctrl
